// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad/timer front end.
package microwave_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BUF_W      = NUM_DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = DIGIT_W'(5);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // MM:SS entry as four BCD digits, most significant first
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_units;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_units;
  } mmss_t;

  // Limit the seconds-tens digit so the timer never sees more than 59 seconds
  function automatic logic [BUF_W-1:0] sec_clamp(input logic [BUF_W-1:0] value);
    mmss_t t;
    t = mmss_t'(value);
    if (t.sec_tens > SEC_TENS_MAX) begin
      t.sec_tens = SEC_TENS_MAX;
    end
    return BUF_W'(t);
  endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Four-digit BCD entry buffer: shifts digits in from the right, clears, and
// optionally clamps the seconds-tens digit in place.
module digit_shift_reg
  import microwave_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clear,
  input  logic               clamp,
  output logic [BUF_W-1:0]   buffer
);

  // Clear wins over clamp, clamp over shift; the controller never asserts two at once
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      buffer <= '0;
    end else if (clear) begin
      buffer <= '0;
    end else if (clamp) begin
      buffer <= sec_clamp(buffer);
    end else if (shift) begin
      buffer <= {buffer[BUF_W-DIGIT_W-1:0], digit};
    end
  end

endmodule

// File: rtl/time_loader.sv
// Keypad front end for the countdown timer: digit entry, load strobe, tick
// gating and pause/abort/done sequencing. Define SEC_CLAMP_EN to clamp the
// seconds-tens digit to 5 when the entry is loaded.
module time_loader
  import microwave_pkg::*;
(
  input  logic               clk,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_start,
  input  logic               key_clear,
  input  logic               door_closed,
  input  logic               sec_tick,
  input  logic               timer_zero,
  output logic [BUF_W-1:0]   load_data,
  output logic               loadn,
  output logic               timer_en,
  output logic [BUF_W-1:0]   display,
  output logic               busy,
  output logic               done
);

  state_t           state;
  state_t           next_state;
  logic             tick_seen;
  logic             buf_shift;
  logic             buf_clear;
  logic             buf_clamp;
  logic             to_load;
  logic             busy_next;
  logic             done_next;
  logic [BUF_W-1:0] load_value;

  digit_shift_reg u_entry (
    .clk    (clk),
    .clrn   (clrn),
    .shift  (buf_shift),
    .digit  (key_digit),
    .clear  (buf_clear),
    .clamp  (buf_clamp),
    .buffer (display)
  );

  // Only real counting ticks reach the timer, and never outside RUN
  assign timer_en = (state == RUN) & sec_tick & door_closed;

`ifdef SEC_CLAMP_EN
  assign buf_clamp  = to_load;
  assign load_value = sec_clamp(display);
`else
  assign buf_clamp  = 1'b0;
  assign load_value = display;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and entry-buffer controls; key_clear > key_start > key_valid
  always_comb begin
    next_state = state;
    buf_shift  = 1'b0;
    buf_clear  = 1'b0;
    to_load    = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (key_clear) begin
          buf_clear = 1'b1;
        end else if (key_start) begin
          if ((display != '0) && door_closed) begin
            next_state = LOAD;
            to_load    = 1'b1;
          end
        end else if (key_valid && (key_digit <= DIGIT_MAX)) begin
          buf_shift = 1'b1;
        end
      end
      LOAD: begin
        next_state = RUN;
      end
      RUN: begin
        if (key_clear) begin
          next_state = IDLE;
          buf_clear  = 1'b1;
        end else if (!door_closed) begin
          next_state = PAUSE;
        end else if (timer_zero && tick_seen) begin
          next_state = DONE;
        end
      end
      PAUSE: begin
        if (key_clear) begin
          next_state = IDLE;
          buf_clear  = 1'b1;
        end else if (key_start && door_closed) begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (key_valid || key_start || key_clear) begin
          next_state = IDLE;
          buf_clear  = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    busy_next = (next_state == LOAD) || (next_state == RUN) || (next_state == PAUSE);
    done_next = (next_state == DONE);
  end

  // Load strobe and data launch together so the timer sees them in the LOAD cycle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      loadn     <= 1'b1;
      load_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      loadn <= ~to_load;
      busy  <= busy_next;
      done  <= done_next;
      if (to_load) begin
        load_data <= load_value;
      end
    end
  end

  // Zero from the timer means nothing until it has actually counted since the load
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tick_seen <= 1'b0;
    end else if (state == LOAD) begin
      tick_seen <= 1'b0;
    end else if (timer_en) begin
      tick_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_time_loader.sv
// Scoreboard bench for time_loader: a per-cycle reference model pushes expected
// outputs and expected load values; a negedge monitor pops and compares.
module tb_time_loader;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_start = 1'b0;
  logic        key_clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        sec_tick = 1'b0;
  logic        timer_zero = 1'b0;
  logic [15:0] load_data;
  logic        loadn;
  logic        timer_en;
  logic [15:0] display;
  logic        busy;
  logic        done;

  time_loader dut (
    .clk         (clk),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_start   (key_start),
    .key_clear   (key_clear),
    .door_closed (door_closed),
    .sec_tick    (sec_tick),
    .timer_zero  (timer_zero),
    .load_data   (load_data),
    .loadn       (loadn),
    .timer_en    (timer_en),
    .display     (display),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        loadn;
    logic [15:0] load_data;
    logic [15:0] display;
    logic        timer_en;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] load_q[$];

  int checks = 0;
  int passed = 0;

  // Reference model: operating mode plus the observable registers
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int          mode;
  logic [15:0] buf_m;
  logic [15:0] ld_m;
  bit          loadn_m, busy_m, done_m, counted_m;

  bit door_lvl = 1'b1;
  bit zero_lvl = 1'b0;
  bit rst_lvl  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  function automatic logic [15:0] clamp_m(input logic [15:0] v);
    int tens;
    tens = (int'(v) / 16) % 16;
    if (tens > 5) return 16'(int'(v) - (tens - 5) * 16);
    return v;
  endfunction

  task automatic model_reset();
    mode = M_IDLE; buf_m = 16'h0; ld_m = 16'h0;
    loadn_m = 1'b1; busy_m = 1'b0; done_m = 1'b0; counted_m = 1'b0;
  endtask

  // One clock cycle: drive inputs, record expected outputs, advance the model
  task automatic step(input bit v, input bit [3:0] d, input bit s, input bit c, input bit tk);
    exp_t e;
    int   nmode;
    logic [15:0] nbuf;
    bit   ncount;
    @(posedge clk); #1;
    key_valid = v; key_digit = d; key_start = s; key_clear = c; sec_tick = tk;
    door_closed = door_lvl; timer_zero = zero_lvl; clrn = ~rst_lvl;
    if (rst_lvl) model_reset();
    e.loadn = loadn_m; e.load_data = ld_m; e.display = buf_m;
    e.busy = busy_m; e.done = done_m;
    e.timer_en = (mode == M_RUN) && tk && door_lvl;
    exp_q.push_back(e);
    if (!rst_lvl) begin
      nmode = mode; nbuf = buf_m; ncount = counted_m;
      case (mode)
        M_IDLE: begin
          if (c) nbuf = 16'h0;
          else if (s) begin
            if (buf_m != 16'h0 && door_lvl) begin
              nmode = M_LOAD;
`ifdef SEC_CLAMP_EN
              nbuf = clamp_m(buf_m);
`endif
              ld_m = nbuf;
              load_q.push_back(nbuf);
            end
          end else if (v && d <= 4'd9) nbuf = 16'((int'(buf_m) * 16 + int'(d)) % 65536);
        end
        M_LOAD: begin nmode = M_RUN; ncount = 1'b0; end
        M_RUN: begin
          if (tk && door_lvl) ncount = 1'b1;
          if (c) begin nmode = M_IDLE; nbuf = 16'h0; end
          else if (!door_lvl) nmode = M_PAUSE;
          else if (zero_lvl && counted_m) nmode = M_DONE;
        end
        M_PAUSE: begin
          if (c) begin nmode = M_IDLE; nbuf = 16'h0; end
          else if (s && door_lvl) nmode = M_RUN;
        end
        default: begin
          if (v || s || c) begin nmode = M_IDLE; nbuf = 16'h0; end
        end
      endcase
      mode = nmode; buf_m = nbuf; counted_m = ncount;
      loadn_m = (nmode != M_LOAD);
      busy_m  = (nmode == M_LOAD) || (nmode == M_RUN) || (nmode == M_PAUSE);
      done_m  = (nmode == M_DONE);
    end
  endtask

  task automatic key(input bit [3:0] d);   step(1, d, 0, 0, 0); endtask
  task automatic start();                  step(0, 0, 1, 0, 0); endtask
  task automatic clear();                  step(0, 0, 0, 1, 0); endtask
  task automatic tick();                   step(0, 0, 0, 0, 1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle's outputs against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("loadn",     16'(loadn),    16'(e.loadn));
      check("load_data", load_data,     e.load_data);
      check("display",   display,       e.display);
      check("timer_en",  16'(timer_en), 16'(e.timer_en));
      check("busy",      16'(busy),     16'(e.busy));
      check("done",      16'(done),     16'(e.done));
    end
    if (loadn === 1'b0) begin
      if (load_q.size() == 0) check("unexpected_load", 16'h1, 16'h0);
      else check("load_event", load_data, load_q.pop_front());
    end
  end

  initial begin
    int r;
    model_reset();
    rst_lvl = 1; idle(2); rst_lvl = 0;

    // 1,3,0 then start; ticks; door open/close; resume
    door_lvl = 1;
    key(1); key(3); key(0); start(); idle(1);
    tick(); idle(1); tick(); tick();
    door_lvl = 0; idle(1); tick(); idle(1);
    door_lvl = 1; start(); tick(); idle(1); tick(); clear();

    // Shift-out of MSD and ignored non-BCD key
    key(1); key(2); key(3); key(4); key(5); key(4'hB); idle(1); clear();

    // Start refused: empty buffer, then door open
    start(); idle(1);
    key(7); door_lvl = 0; start(); idle(1); door_lvl = 1; clear();

    // Zero before any tick, then after one tick, then exit DONE by a digit
    key(5); start(); idle(1);
    zero_lvl = 1; idle(3); tick(); idle(2);
    key(3); zero_lvl = 0; idle(1);

    // Seconds-tens clamp behaviour
    key(1); key(7); key(0); start(); idle(2); clear();

    // Clear and start together
    key(4); step(0, 0, 1, 1, 0); idle(2);

    // Reset mid-run
    key(9); start(); tick(); idle(1);
    rst_lvl = 1; idle(1); rst_lvl = 0; idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) door_lvl = ~door_lvl;
      else if (r < 6) zero_lvl = ~zero_lvl;
      else if (r == 6 && i > 100) rst_lvl = 1;
      step($urandom_range(0, 99) < 25, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 30);
      rst_lvl = 0;
      if (!door_lvl && $urandom_range(0, 99) < 10) door_lvl = 1;
    end
    idle(1);
    @(posedge clk); @(negedge clk); #1;
    check("queues_drained", 16'(exp_q.size() + load_q.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
